// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants, types and helpers for the oversampled
//                SPI slave (byte width, synchronizer depth, mode encoding,
//                FSM state type).
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  // Mode encoding is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [0:0] {
    SPI_ST_IDLE   = 1'b0,
    SPI_ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_allmodes_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_allmodes_if
//  Description : Byte-wide user-side interface of the SPI slave.
//                slave modport  : mode select, TX load in; RX data and
//                                 status out.
//                master modport : the user logic driving the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_slave_allmodes_if;
  import spi_pkg::*;

  logic                  i_CPOL;
  logic                  i_CPHA;
  logic [SPI_BYTE_W-1:0] i_TX_Byte;
  logic                  i_TX_DV;
  logic                  o_TX_Ready;
  logic                  o_TX_Underrun;
  logic                  o_RX_DV;
  logic [SPI_BYTE_W-1:0] o_RX_Byte;
  logic                  o_CS_Active;

  modport slave (
    input  i_CPOL, i_CPHA, i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active
  );

  modport master (
    output i_CPOL, i_CPHA, i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_CS_Active
  );

endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Multi-flop synchronizer for one asynchronous pin plus a
//                history flop for edge detection.
//  Ports       : i_Clk, i_Rst  system clock / synchronous active-high reset
//                i_pin         asynchronous pin
//                o_level       synchronized level (history stage)
//                o_rise/o_fall registered one-cycle edge flags
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  wire  i_Clk,
  input  wire  i_Rst,
  input  wire  i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              r_fall;

  // Edge flags are registered: a pin change captured in r_sync[0] at edge N
  // shows up on o_rise/o_fall after edge N+2.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_hist <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_hist;
      r_fall <= ~r_sync[STAGES-1] & r_hist;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_slave_allmodes.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_allmodes
//  Description : Oversampled SPI slave for all four CPOL/CPHA modes, fully
//                in the system clock domain. MSB-first in both directions,
//                single-byte TX holding register, multi-byte bursts.
//  Ports       : i_Clk, i_Rst        system clock / sync active-high reset
//                io_user (slave)     mode select, TX load/ready/underrun,
//                                    RX byte/valid, CS active
//                i_SPI_Clk/MOSI/CS_n asynchronous SPI pins
//                o_SPI_MISO(_En)     MISO data and output enable
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_allmodes
  import spi_pkg::*;
#(
  parameter int CLKS_MIN_HALF_BIT = 8
) (
  input  wire                   i_Clk,
  input  wire                   i_Rst,
  spi_slave_allmodes_if.slave   io_user,
  input  wire                   i_SPI_Clk,
  input  wire                   i_SPI_MOSI,
  input  wire                   i_SPI_CS_n,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En
);

  localparam int CNT_W = $clog2(SPI_BYTE_W);

  // The pin-to-output path is 3 cycles; anything shorter than that per
  // half-bit cannot be tracked.
  generate
    if (CLKS_MIN_HALF_BIT < 4) begin : g_half_bit_check
      $error("CLKS_MIN_HALF_BIT too small for the 3-cycle pin latency");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pin conditioning
  // --------------------------------------------------------------------------
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_csn_lvl,  w_csn_rise,  w_csn_fall;
  logic w_mosi,     w_mosi_rise, w_mosi_fall;
  logic w_unused_pins;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_Clk (i_Clk), .i_Rst (i_Rst), .i_pin (i_SPI_Clk),
    .o_level (w_sclk_lvl), .o_rise (w_sclk_rise), .o_fall (w_sclk_fall)
  );

  // CS_n resets to "asserted" so that a CS_n still low after reset produces
  // no falling edge: a new frame only starts after CS_n was seen high.
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_csn (
    .i_Clk (i_Clk), .i_Rst (i_Rst), .i_pin (i_SPI_CS_n),
    .o_level (w_csn_lvl), .o_rise (w_csn_rise), .o_fall (w_csn_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_Clk (i_Clk), .i_Rst (i_Rst), .i_pin (i_SPI_MOSI),
    .o_level (w_mosi), .o_rise (w_mosi_rise), .o_fall (w_mosi_fall)
  );

  assign w_unused_pins = ^{w_sclk_lvl, w_csn_lvl, w_mosi_rise, w_mosi_fall};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  spi_state_e            r_state,     w_state_nxt;
  logic                  r_cpol,      w_cpol_nxt;
  logic                  r_cpha,      w_cpha_nxt;
  logic [CNT_W-1:0]      r_bit_cnt,   w_bit_cnt_nxt;
  logic [SPI_BYTE_W-1:0] r_rx_shift,  w_rx_shift_nxt;
  logic [SPI_BYTE_W-1:0] r_rx_byte,   w_rx_byte_nxt;
  logic                  r_rx_dv,     w_rx_dv_nxt;
  logic [SPI_BYTE_W-1:0] r_tx_shift,  w_tx_shift_nxt;
  logic                  r_miso,      w_miso_nxt;
  logic                  r_miso_en,   w_miso_en_nxt;
  logic                  r_reload,    w_reload_nxt;
  logic                  r_msb_next,  w_msb_next_nxt;
  logic [SPI_BYTE_W-1:0] r_hold,      w_hold_nxt;
  logic                  r_hold_full, w_hold_full_nxt;
  logic                  r_underrun,  w_underrun_nxt;

  logic                  w_xfer;
  logic [SPI_BYTE_W-1:0] w_xfer_byte;
  logic                  w_tx_load;
  logic                  w_sample_edge;
  logic                  w_shift_edge;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= SPI_ST_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_byte   <= '0;
      r_rx_dv     <= 1'b0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_miso_en   <= 1'b0;
      r_reload    <= 1'b0;
      r_msb_next  <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpol      <= w_cpol_nxt;
      r_cpha      <= w_cpha_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_byte   <= w_rx_byte_nxt;
      r_rx_dv     <= w_rx_dv_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_miso      <= w_miso_nxt;
      r_miso_en   <= w_miso_en_nxt;
      r_reload    <= w_reload_nxt;
      r_msb_next  <= w_msb_next_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Edge roles from the latched mode
  // --------------------------------------------------------------------------
  always_comb begin
    w_sample_edge = 1'b0;
    w_shift_edge  = 1'b0;
    case (spi_mode(r_cpol, r_cpha))
      SPI_MODE0: begin w_sample_edge = w_sclk_rise; w_shift_edge = w_sclk_fall; end
      SPI_MODE1: begin w_sample_edge = w_sclk_fall; w_shift_edge = w_sclk_rise; end
      SPI_MODE2: begin w_sample_edge = w_sclk_fall; w_shift_edge = w_sclk_rise; end
      SPI_MODE3: begin w_sample_edge = w_sclk_rise; w_shift_edge = w_sclk_fall; end
      default:   begin w_sample_edge = 1'b0;        w_shift_edge = 1'b0;        end
    endcase
  end

  // --------------------------------------------------------------------------
  // TX holding register. A transfer always takes the current contents (or
  // 0x00 when empty); a load is only possible while empty.
  // --------------------------------------------------------------------------
  always_comb begin
    w_xfer_byte     = r_hold_full ? r_hold : '0;
    w_tx_load       = io_user.i_TX_DV & ~r_hold_full;
    w_hold_nxt      = w_tx_load ? io_user.i_TX_Byte : r_hold;
    w_hold_full_nxt = w_tx_load | (r_hold_full & ~w_xfer);
    w_underrun_nxt  = w_xfer & ~r_hold_full;
  end

  // --------------------------------------------------------------------------
  // Frame FSM and shift datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cpol_nxt     = r_cpol;
    w_cpha_nxt     = r_cpha;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_dv_nxt    = 1'b0;
    w_tx_shift_nxt = r_tx_shift;
    w_miso_nxt     = r_miso;
    w_miso_en_nxt  = r_miso_en;
    w_reload_nxt   = r_reload;
    w_msb_next_nxt = r_msb_next;
    w_xfer         = 1'b0;

    case (r_state)
      SPI_ST_IDLE: begin
        w_miso_en_nxt = 1'b0;
        if (w_csn_fall) begin
          w_state_nxt    = SPI_ST_ACTIVE;
          w_cpol_nxt     = io_user.i_CPOL;
          w_cpha_nxt     = io_user.i_CPHA;
          w_bit_cnt_nxt  = '0;
          w_reload_nxt   = 1'b0;
          // With CPHA=1 the first leading edge re-presents the MSB instead
          // of shifting; driving it already now keeps MISO defined early.
          w_msb_next_nxt = io_user.i_CPHA;
          w_xfer         = 1'b1;
          w_tx_shift_nxt = w_xfer_byte;
          w_miso_nxt     = w_xfer_byte[SPI_BYTE_W-1];
          w_miso_en_nxt  = 1'b1;
        end
      end

      SPI_ST_ACTIVE: begin
        if (w_csn_rise) begin
          // Partial byte is dropped; the holding register is untouched.
          w_state_nxt    = SPI_ST_IDLE;
          w_bit_cnt_nxt  = '0;
          w_miso_en_nxt  = 1'b0;
          w_reload_nxt   = 1'b0;
          w_msb_next_nxt = 1'b0;
        end else begin
          if (w_sample_edge) begin
            w_rx_shift_nxt = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
            w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_W'(SPI_BYTE_W - 1)) begin
              w_rx_byte_nxt = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
              w_rx_dv_nxt   = 1'b1;
              w_reload_nxt  = 1'b1;
            end
          end
          if (w_shift_edge) begin
            if (r_msb_next) begin
              w_miso_nxt     = r_tx_shift[SPI_BYTE_W-1];
              w_msb_next_nxt = 1'b0;
            end else if (r_reload) begin
              // Byte boundary inside a burst
              w_xfer         = 1'b1;
              w_tx_shift_nxt = w_xfer_byte;
              w_miso_nxt     = w_xfer_byte[SPI_BYTE_W-1];
              w_reload_nxt   = 1'b0;
            end else begin
              w_tx_shift_nxt = {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
              w_miso_nxt     = r_tx_shift[SPI_BYTE_W-2];
            end
          end
        end
      end

      default: begin
        w_state_nxt = SPI_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io_user.o_TX_Ready    = ~r_hold_full;
  assign io_user.o_TX_Underrun = r_underrun;
  assign io_user.o_RX_DV       = r_rx_dv;
  assign io_user.o_RX_Byte     = r_rx_byte;
  assign io_user.o_CS_Active   = (r_state == SPI_ST_ACTIVE);
  assign o_SPI_MISO            = r_miso;
  assign o_SPI_MISO_En         = r_miso_en;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_allmodes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_allmodes
//  Description : Self-checking bench for spi_slave_allmodes. A behavioural
//                SPI master drives the pins; expected RX bytes go into a
//                scoreboard queue and are matched on every o_RX_DV pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_allmodes;
  import spi_pkg::*;

  localparam int HALF = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_cs_n = 1'b1;
  logic miso;
  logic miso_en;

  always #5 clk = ~clk;

  spi_slave_allmodes_if bus ();

  spi_slave_allmodes #(.CLKS_MIN_HALF_BIT(8)) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .io_user       (bus),
    .i_SPI_Clk     (spi_clk),
    .i_SPI_MOSI    (spi_mosi),
    .i_SPI_CS_n    (spi_cs_n),
    .o_SPI_MISO    (miso),
    .o_SPI_MISO_En (miso_en)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_udr   = 0;
  logic [7:0] q_rx [$];
  logic [7:0] sb_last = 8'h00;

  task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every RX_DV must match the oldest pushed byte.
  always @(negedge clk) begin
    if (bus.o_TX_Underrun === 1'b1) n_udr++;
    if (bus.o_RX_DV === 1'b1) begin
      t_check("rx_sb_nonempty", 32'(q_rx.size() > 0), 32'd1);
      if (q_rx.size() > 0) begin
        sb_last = q_rx.pop_front();
        t_check("rx_byte", 32'(bus.o_RX_Byte), 32'(sb_last));
      end
    end
  end

  // Transfers per frame: one at CS start, one per further byte, plus the
  // trailing boundary after the last byte when CPHA=0.
  function automatic int f_exp_udr(input logic cpha, input int nbytes, input int nloaded);
    return nbytes + (cpha ? 0 : 1) - nloaded;
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    int t = 0;
    while (bus.o_TX_Ready !== 1'b1 && t < 200) begin
      wait_neg(1);
      t++;
    end
    t_check("ready_wait", 32'(bus.o_TX_Ready), 32'd1);
    bus.i_TX_Byte = b;
    bus.i_TX_DV   = 1'b1;
    wait_neg(1);
    bus.i_TX_DV   = 1'b0;
    t_check("ready_drop", 32'(bus.o_TX_Ready), 32'd0);
  endtask

  task automatic cs_start(input logic [1:0] mode, input logic exp_msb, input logic loaded);
    bus.i_CPOL = mode[1];
    bus.i_CPHA = mode[0];
    spi_clk    = mode[1];
    wait_neg(8);
    spi_cs_n = 1'b0;
    wait_neg(3);
    t_check("cs_act_early", 32'(bus.o_CS_Active), 32'd0);
    t_check("ready_early", 32'(bus.o_TX_Ready), 32'(!loaded));
    wait_neg(1);
    t_check("cs_act", 32'(bus.o_CS_Active), 32'd1);
    t_check("miso_en_on", 32'(miso_en), 32'd1);
    t_check("miso_msb", 32'(miso), 32'(exp_msb));
    t_check("ready_after_start", 32'(bus.o_TX_Ready), 32'd1);
    wait_neg(HALF - 4);
  endtask

  task automatic master_bits(input logic [1:0] mode, input logic [7:0] tx,
                             input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!mode[0]) begin
        spi_mosi = tx[i];
        wait_neg(HALF);
        spi_clk = ~mode[1];
        rx[i]   = miso;
        wait_neg(HALF);
        spi_clk = mode[1];
      end else begin
        spi_clk  = ~mode[1];
        spi_mosi = tx[i];
        wait_neg(HALF);
        spi_clk = mode[1];
        rx[i]   = miso;
        wait_neg(HALF);
      end
    end
  endtask

  task automatic cs_end();
    wait_neg(HALF);
    spi_cs_n = 1'b1;
    wait_neg(6);
    t_check("miso_en_off", 32'(miso_en), 32'd0);
    t_check("cs_idle", 32'(bus.o_CS_Active), 32'd0);
    t_check("sb_drained", 32'(q_rx.size()), 32'd0);
    wait_neg(HALF);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         u0;
    logic [1:0] m;

    bus.i_CPOL = 1'b0; bus.i_CPHA = 1'b0;
    bus.i_TX_Byte = 8'h00; bus.i_TX_DV = 1'b0;
    wait_neg(5);
    rst = 1'b0;
    wait_neg(2);
    t_check("rst_ready", 32'(bus.o_TX_Ready), 32'd1);
    t_check("rst_udr", 32'(bus.o_TX_Underrun), 32'd0);
    t_check("rst_rx_dv", 32'(bus.o_RX_DV), 32'd0);
    t_check("rst_rx_byte", 32'(bus.o_RX_Byte), 32'd0);
    t_check("rst_cs_act", 32'(bus.o_CS_Active), 32'd0);
    t_check("rst_miso", 32'(miso), 32'd0);
    t_check("rst_miso_en", 32'(miso_en), 32'd0);

    // Mode 0 exchange; a second load while full must be ignored
    load_tx(8'hA5);
    bus.i_TX_Byte = 8'hEE; bus.i_TX_DV = 1'b1;
    wait_neg(1);
    bus.i_TX_DV = 1'b0;
    u0 = n_udr;
    q_rx.push_back(8'h3C);
    cs_start(SPI_MODE0, 1'b1, 1'b1);
    master_bits(SPI_MODE0, 8'h3C, 8, rx);
    t_check("m0_miso_byte", 32'(rx), 32'hA5);
    cs_end();
    t_check("m0_udr", 32'(n_udr - u0), 32'(f_exp_udr(1'b0, 1, 1)));

    // Same exchange in all four modes
    for (int k = 0; k < 4; k++) begin
      m = 2'(k);
      load_tx(8'h81);
      u0 = n_udr;
      q_rx.push_back(8'h5A);
      cs_start(m, 1'b1, 1'b1);
      master_bits(m, 8'h5A, 8, rx);
      t_check("modes_miso_byte", 32'(rx), 32'h81);
      cs_end();
      t_check("modes_udr", 32'(n_udr - u0), 32'(f_exp_udr(m[0], 1, 1)));
    end

    // Two-byte burst, mode 3
    load_tx(8'h11);
    u0 = n_udr;
    q_rx.push_back(8'hF0);
    q_rx.push_back(8'h0F);
    cs_start(SPI_MODE3, 1'b0, 1'b1);
    load_tx(8'h22);
    master_bits(SPI_MODE3, 8'hF0, 8, rx);
    t_check("burst_b0", 32'(rx), 32'h11);
    master_bits(SPI_MODE3, 8'h0F, 8, rx);
    t_check("burst_b1", 32'(rx), 32'h22);
    cs_end();
    t_check("burst_udr", 32'(n_udr - u0), 32'(f_exp_udr(1'b1, 2, 2)));

    // Underrun: nothing loaded, mode 1
    u0 = n_udr;
    q_rx.push_back(8'hC3);
    cs_start(SPI_MODE1, 1'b0, 1'b0);
    t_check("udr_at_start", 32'(n_udr - u0), 32'd1);
    master_bits(SPI_MODE1, 8'hC3, 8, rx);
    t_check("udr_miso_byte", 32'(rx), 32'h00);
    cs_end();
    t_check("udr_total", 32'(n_udr - u0), 32'(f_exp_udr(1'b1, 1, 0)));

    // CS abort after 5 bits, then a clean byte
    load_tx(8'h77);
    u0 = n_udr;
    cs_start(SPI_MODE0, 1'b0, 1'b1);
    master_bits(SPI_MODE0, 8'hC3, 5, rx);
    t_check("abort_partial_miso", 32'(rx), 32'h70);
    cs_end();
    t_check("abort_rx_kept", 32'(bus.o_RX_Byte), 32'(sb_last));
    t_check("abort_udr", 32'(n_udr - u0), 32'd0);
    load_tx(8'h96);
    u0 = n_udr;
    q_rx.push_back(8'h69);
    cs_start(SPI_MODE0, 1'b1, 1'b1);
    master_bits(SPI_MODE0, 8'h69, 8, rx);
    t_check("post_abort_miso", 32'(rx), 32'h96);
    cs_end();
    t_check("post_abort_udr", 32'(n_udr - u0), 32'(f_exp_udr(1'b0, 1, 1)));

    // Reset at bit 3 with CS held low
    load_tx(8'hAB);
    cs_start(SPI_MODE1, 1'b1, 1'b1);
    master_bits(SPI_MODE1, 8'h55, 3, rx);
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    wait_neg(1);
    sb_last = 8'h00;
    t_check("mrst_ready", 32'(bus.o_TX_Ready), 32'd1);
    t_check("mrst_rx_byte", 32'(bus.o_RX_Byte), 32'd0);
    t_check("mrst_cs_act", 32'(bus.o_CS_Active), 32'd0);
    t_check("mrst_miso_en", 32'(miso_en), 32'd0);
    t_check("mrst_miso", 32'(miso), 32'd0);
    master_bits(SPI_MODE1, 8'h55, 5, rx);
    t_check("mrst_ignored_en", 32'(miso_en), 32'd0);
    cs_end();
    load_tx(8'h3E);
    u0 = n_udr;
    q_rx.push_back(8'hE3);
    cs_start(SPI_MODE1, 1'b0, 1'b1);
    master_bits(SPI_MODE1, 8'hE3, 8, rx);
    t_check("post_rst_miso", 32'(rx), 32'h3E);
    cs_end();
    t_check("post_rst_udr", 32'(n_udr - u0), 32'(f_exp_udr(1'b1, 1, 1)));

    wait_neg(20);
    t_check("sb_final", 32'(q_rx.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
